// File: rtl/alu_defs.sv
// Shared widths, ALU opcodes and issue-controller state encoding.
package alu_defs;

    localparam int ALU_W   = 8;
    localparam int ALU_OPW = 3;
    localparam int ALU_RW  = 2 * ALU_W;

    localparam logic [ALU_OPW-1:0] OP_ADD = 3'd0;
    localparam logic [ALU_OPW-1:0] OP_SUB = 3'd1;
    localparam logic [ALU_OPW-1:0] OP_MUL = 3'd2;
    localparam logic [ALU_OPW-1:0] OP_AND = 3'd3;
    localparam logic [ALU_OPW-1:0] OP_OR  = 3'd4;
    localparam logic [ALU_OPW-1:0] OP_XOR = 3'd5;
    localparam logic [ALU_OPW-1:0] OP_SHL = 3'd6;
    localparam logic [ALU_OPW-1:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Launches one request onto the combinational ALU, captures the result SETTLE edges later.
// Response is held until rsp_ready; a new request can ride the response transfer edge.
module alu_issue_ctrl
    import alu_defs::*;
#(
    parameter int W      = ALU_W,
    parameter int OPW    = ALU_OPW,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [W-1:0]   req_a,
    input  logic [W-1:0]   req_b,
    input  logic           req_cin,
    input  logic [OPW-1:0] req_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_cin,
    output logic [OPW-1:0] alu_op,
    input  logic [2*W-1:0] alu_res,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_res,
    output logic [OPW-1:0] rsp_op,
    output logic           rsp_zero,
    output logic           busy,
    output logic [7:0]     issue_count
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic           alu_cin_q, alu_cin_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic [2*W-1:0] rsp_res_q, rsp_res_d;
    logic [OPW-1:0] rsp_op_q, rsp_op_d;
    logic           rsp_zero_q, rsp_zero_d;
    logic [7:0]     issue_count_q, issue_count_d;
    logic           load;

    // A response transfer frees the slot in the same cycle, so ready follows rsp_ready.
    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    assign load      = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_cin_d     = alu_cin_q;
        alu_op_d      = alu_op_q;
        rsp_res_d     = rsp_res_q;
        rsp_op_d      = rsp_op_q;
        rsp_zero_d    = rsp_zero_q;
        issue_count_d = issue_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid) state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_res_d  = alu_res;
                    rsp_op_d   = alu_op_q;
                    rsp_zero_d = (alu_res == '0);
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = req_valid ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            alu_a_d       = req_a;
            alu_b_d       = req_b;
            alu_cin_d     = req_cin;
            alu_op_d      = req_op;
            cnt_d         = CNT_INIT;
            issue_count_d = issue_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_cin_q     <= 1'b0;
            alu_op_q      <= '0;
            rsp_res_q     <= '0;
            rsp_op_q      <= '0;
            rsp_zero_q    <= 1'b0;
            issue_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_cin_q     <= alu_cin_d;
            alu_op_q      <= alu_op_d;
            rsp_res_q     <= rsp_res_d;
            rsp_op_q      <= rsp_op_d;
            rsp_zero_q    <= rsp_zero_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_cin     = alu_cin_q;
    assign alu_op      = alu_op_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_res     = rsp_res_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_zero    = rsp_zero_q;
    assign busy        = (state_q != IDLE);
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: one instance with SETTLE=1 and one with SETTLE=4, selected by sel.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  op;
    } exp_t;

    logic clk, rst, sel;
    logic req_valid, rsp_ready, req_cin;
    logic [7:0] req_a, req_b;
    logic [2:0] req_op;

    logic vld_1, rdy_1, cin_1, rr_1, rv_1, rz_1, busy_1;
    logic [7:0] a_1, b_1, ic_1;
    logic [2:0] op_1, ro_1;
    logic [15:0] res_1, rres_1;
    logic vld_4, rdy_4, cin_4, rr_4, rv_4, rz_4, busy_4;
    logic [7:0] a_4, b_4, ic_4;
    logic [2:0] op_4, ro_4;
    logic [15:0] res_4, rres_4;

    logic req_ready_m, rsp_valid_m, rsp_zero_m, busy_m;
    logic [7:0] alu_a_m, ic_m;
    logic [2:0] rsp_op_m;
    logic [15:0] rsp_res_m;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   issued[2];
    exp_t exp_q[$];
    int   acc_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign vld_1 = req_valid & ~sel;
    assign vld_4 = req_valid & sel;
    assign rr_1  = sel ? 1'b1 : rsp_ready;
    assign rr_4  = sel ? rsp_ready : 1'b1;
    assign res_1 = {8'h00, a_1} * {8'h00, b_1} + {15'h0, cin_1};
    assign res_4 = {8'h00, a_4} * {8'h00, b_4} + {15'h0, cin_4};

    assign req_ready_m = sel ? rdy_4  : rdy_1;
    assign rsp_valid_m = sel ? rv_4   : rv_1;
    assign rsp_zero_m  = sel ? rz_4   : rz_1;
    assign rsp_res_m   = sel ? rres_4 : rres_1;
    assign rsp_op_m    = sel ? ro_4   : ro_1;
    assign busy_m      = sel ? busy_4 : busy_1;
    assign alu_a_m     = sel ? a_4    : a_1;
    assign ic_m        = sel ? ic_4   : ic_1;

    alu_issue_ctrl #(.W(8), .OPW(3), .SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .req_valid(vld_1), .req_ready(rdy_1),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op),
        .alu_a(a_1), .alu_b(b_1), .alu_cin(cin_1), .alu_op(op_1), .alu_res(res_1),
        .rsp_valid(rv_1), .rsp_ready(rr_1), .rsp_res(rres_1), .rsp_op(ro_1),
        .rsp_zero(rz_1), .busy(busy_1), .issue_count(ic_1)
    );

    alu_issue_ctrl #(.W(8), .OPW(3), .SETTLE(4)) u_s4 (
        .clk(clk), .rst(rst), .req_valid(vld_4), .req_ready(rdy_4),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op),
        .alu_a(a_4), .alu_b(b_4), .alu_cin(cin_4), .alu_op(op_4), .alu_res(res_4),
        .rsp_valid(rv_4), .rsp_ready(rr_4), .rsp_res(rres_4), .rsp_op(ro_4),
        .rsp_zero(rz_4), .busy(busy_4), .issue_count(ic_4)
    );

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic cin);
        return {8'h00, a} * {8'h00, b} + {15'h0, cin};
    endfunction

    // Presents one request (called on a negedge) and returns on the negedge after its accept edge.
    task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic [2:0] op, output bit ok);
        req_a = a; req_b = b; req_cin = cin; req_op = op; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (req_ready_m) begin
                exp_q.push_back('{model(a, b, cin), op});
                acc_q.push_back(cyc + 1);
                issued[sel] = issued[sel] + 1;
                ok = 1'b1;
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (rsp_valid_m) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        bit seen;
        sel = 1'b0; rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_cin = 1'b0; req_op = '0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready_m !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready_m); end
        checks++; if (rsp_valid_m !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_m); end
        checks++; if (rsp_res_m !== 16'h0) begin errors++; $display("FAIL reset_rsp_res got=%h want=0", rsp_res_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_m); end
        rst = 1'b0;
        @(negedge clk);
        sel = 1'b1;
        send_req(8'h12, 8'h05, 1'b0, 3'd1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_accept timeout"); end
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL midwait_busy got=%b want=1", busy_m); end
        checks++; if (alu_a_m !== 8'h12) begin errors++; $display("FAIL midwait_alu_a got=%h want=12", alu_a_m); end
        #1 rst = 1'b1;
        #1;
        exp_q.delete(); acc_q.delete(); issued[0] = 0; issued[1] = 0;
        checks++; if (req_ready_m !== 1'b1) begin errors++; $display("FAIL async_req_ready got=%b want=1", req_ready_m); end
        checks++; if (rsp_valid_m !== 1'b0) begin errors++; $display("FAIL async_rsp_valid got=%b want=0", rsp_valid_m); end
        checks++; if (alu_a_m !== 8'h00) begin errors++; $display("FAIL async_alu_a got=%h want=00", alu_a_m); end
        checks++; if (ic_m !== 8'h00) begin errors++; $display("FAIL async_issue_count got=%h want=00", ic_m); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid_m || busy_m) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_late_rsp got=%b want=0", seen); end
    endtask

    task automatic test_single();
        bit ok;
        exp_t e;
        int ae;
        sel = 1'b0; rsp_ready = 1'b1;
        send_req(8'hFF, 8'hFF, 1'b0, 3'd2, ok);
        wait_rsp(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_rsp timeout"); end
        else begin
            e = exp_q.pop_front(); ae = acc_q.pop_front();
            if (cyc - ae !== 1) begin errors++; $display("FAIL single_latency got=%0d want=1", cyc - ae); end
            checks++; if (rsp_res_m !== e.res) begin errors++; $display("FAIL single_res got=%h want=%h", rsp_res_m, e.res); end
            checks++; if (rsp_op_m !== e.op) begin errors++; $display("FAIL single_op got=%h want=%h", rsp_op_m, e.op); end
            checks++; if (rsp_zero_m !== 1'b0) begin errors++; $display("FAIL single_zero got=%b want=0", rsp_zero_m); end
            @(negedge clk);
            checks++; if (rsp_valid_m !== 1'b0) begin errors++; $display("FAIL single_done got=%b want=0", rsp_valid_m); end
            checks++; if (ic_m !== 8'(issued[0])) begin errors++; $display("FAIL single_count got=%0d want=%0d", ic_m, 8'(issued[0])); end
        end
    endtask

    task automatic test_zero();
        bit ok;
        exp_t e;
        sel = 1'b0; rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send_req(8'h00, 8'h37, k[0], 3'd0, ok);
            wait_rsp(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL zero_rsp%0d timeout", k); end
            else begin
                e = exp_q.pop_front(); void'(acc_q.pop_front());
                if (rsp_res_m !== e.res) begin errors++; $display("FAIL zero_res%0d got=%h want=%h", k, rsp_res_m, e.res); end
                checks++;
                if (rsp_zero_m !== (e.res == 16'h0)) begin
                    errors++; $display("FAIL zero_flag%0d got=%b want=%b", k, rsp_zero_m, (e.res == 16'h0));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        exp_t e;
        sel = 1'b0; rsp_ready = 1'b0;
        send_req(8'h9A, 8'h0B, 1'b1, 3'd5, ok);
        wait_rsp(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_rsp timeout"); end
        else begin
            e = exp_q.pop_front(); void'(acc_q.pop_front());
            for (int i = 0; i < 5; i++) begin
                if (rsp_valid_m !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got=%b want=1", i, rsp_valid_m); end
                checks++; if (rsp_res_m !== e.res) begin errors++; $display("FAIL bp_res%0d got=%h want=%h", i, rsp_res_m, e.res); end
                checks++; if (req_ready_m !== 1'b0) begin errors++; $display("FAIL bp_req_ready%0d got=%b want=0", i, req_ready_m); end
                checks++;
                @(negedge clk);
            end
            checks--;
            rsp_ready = 1'b1;
            @(negedge clk);
            checks++; if (rsp_valid_m !== 1'b0) begin errors++; $display("FAIL bp_single_transfer got=%b want=0", rsp_valid_m); end
        end
    endtask

    task automatic test_back_to_back();
        int n_sent, n_got, last, ae;
        bit acc;
        exp_t e;
        sel = 1'b0; rsp_ready = 1'b1;
        n_sent = 0; n_got = 0; last = 0;
        req_a = 8'd1; req_b = 8'd3; req_cin = 1'b0; req_op = 3'd2; req_valid = 1'b1;
        for (int t = 0; t < 100 && n_got < 4; t++) begin
            acc = req_valid && req_ready_m;
            if (rsp_valid_m) begin
                e = exp_q.pop_front(); ae = acc_q.pop_front();
                checks++; if (rsp_res_m !== e.res) begin errors++; $display("FAIL b2b_res%0d got=%h want=%h", n_got, rsp_res_m, e.res); end
                checks++; if (cyc - ae !== 1) begin errors++; $display("FAIL b2b_latency%0d got=%0d want=1", n_got, cyc - ae); end
                if (n_got > 0) begin
                    checks++; if (cyc - last !== 2) begin errors++; $display("FAIL b2b_spacing%0d got=%0d want=2", n_got, cyc - last); end
                end
                last = cyc; n_got++;
            end
            if (acc) begin
                exp_q.push_back('{model(req_a, req_b, req_cin), req_op});
                acc_q.push_back(cyc + 1);
                issued[0] = issued[0] + 1; n_sent++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (n_sent == 4) req_valid = 1'b0;
                else req_a = req_a + 8'd1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (n_got !== 4) begin errors++; $display("FAIL b2b_count got=%0d want=4", n_got); end
    endtask

    task automatic test_wrap();
        int n_sent, n_got, ae;
        bit acc;
        exp_t e;
        sel = 1'b1; rsp_ready = 1'b1;
        n_sent = 0; n_got = 0;
        req_a = 8'($urandom); req_b = 8'($urandom); req_cin = 1'($urandom); req_op = 3'($urandom);
        req_valid = 1'b1;
        for (int t = 0; t < 3000 && n_got < 256; t++) begin
            acc = req_valid && req_ready_m;
            if (rsp_valid_m) begin
                e = exp_q.pop_front(); ae = acc_q.pop_front();
                checks++; if (rsp_res_m !== e.res) begin errors++; $display("FAIL wrap_res%0d got=%h want=%h", n_got, rsp_res_m, e.res); end
                checks++; if (rsp_op_m !== e.op) begin errors++; $display("FAIL wrap_op%0d got=%h want=%h", n_got, rsp_op_m, e.op); end
                checks++; if (cyc - ae !== 4) begin errors++; $display("FAIL wrap_latency%0d got=%0d want=4", n_got, cyc - ae); end
                checks++; if (ic_m !== 8'(issued[1])) begin errors++; $display("FAIL wrap_count%0d got=%0d want=%0d", n_got, ic_m, 8'(issued[1])); end
                n_got++;
            end
            if (acc) begin
                exp_q.push_back('{model(req_a, req_b, req_cin), req_op});
                acc_q.push_back(cyc + 1);
                issued[1] = issued[1] + 1; n_sent++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (n_sent == 256) req_valid = 1'b0;
                else begin
                    req_a = 8'($urandom); req_b = 8'($urandom); req_cin = 1'($urandom); req_op = 3'($urandom);
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (n_got !== 256) begin errors++; $display("FAIL wrap_rsp_count got=%0d want=256", n_got); end
        @(negedge clk);
        checks++; if (ic_m !== 8'h00) begin errors++; $display("FAIL wrap_final_count got=%0d want=0", ic_m); end
    endtask

    initial begin
        issued[0] = 0; issued[1] = 0;
        test_reset();
        test_single();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential initiator for the 8x8 combinational ALU. It accepts an operand/opcode request over a valid/ready handshake and registers a, b, cin and op onto the ALU inputs. It waits a fixed settle time, captures the 16-bit ALU result, and returns it over a valid/ready response handshake. It sits between a test/control master (e.g. a UART command decoder or CPU port) and the ALU datapath.

Parameters:
W, 8, operand width (ALU a/b width; result width is 2*W)
OPW, 3, opcode width (passed through; block is opcode-agnostic)
SETTLE, 1, clock edges between operand launch and result capture; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept request this cycle
req_a  in  W  operand A
req_b  in  W  operand B
req_cin  in  1  carry in
req_op  in  OPW  ALU opcode
alu_a  out  W  registered operand A to ALU
alu_b  out  W  registered operand B to ALU
alu_cin  out  1  registered carry to ALU
alu_op  out  OPW  registered opcode to ALU
alu_res  in  2*W  ALU result (combinational from alu_*)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_res  out  2*W  captured result
rsp_op  out  OPW  opcode the result belongs to
rsp_zero  out  1  captured result == 0
busy  out  1  state != IDLE
issue_count  out  8  number of accepted requests, wraps 255->0

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0 except req_ready=1. Settle counter is 0. Any in-flight request or undelivered response is discarded; no partial response after rst deasserts.
- States: IDLE, WAIT, RESP.
- Accept: a request transfers on an edge where req_valid && req_ready. req_ready = (state==IDLE) || (state==RESP && rsp_ready).
- On accept: alu_a/b/cin/op <= req_*; issue_count++; cnt <= SETTLE-1; state <= WAIT.
- WAIT: if cnt==0, then rsp_res <= alu_res, rsp_op <= alu_op, rsp_zero <= (alu_res==0), state <= RESP. Otherwise cnt--. req_ready=0.
- Latency: rsp_valid rises exactly SETTLE edges after the accept edge. SETTLE=1 gives rsp_valid high in the cycle after the accept cycle's next edge.
- RESP: rsp_valid=1. rsp_res/op/zero are held stable until the transfer edge (rsp_valid && rsp_ready).
  - On transfer with no new request: state <= IDLE, rsp_valid <= 0.
  - On transfer with a simultaneous req_valid: the new request is accepted on that same edge and state <= WAIT. This gives back-to-back issue with no idle bubble.
  - While RESP is held off by rsp_ready=0: req_ready=0, and the request must be held by the master.
- alu_* keep the last issued operands in IDLE; they do not return to 0.
- rsp_res, rsp_op and rsp_zero keep their last values after transfer. Only rsp_valid qualifies them.
- busy = (state != IDLE).
- Illegal states recover to IDLE on the next edge.

Decomposition:
- Shared include/package alu_defs: W, OPW, result width 2*W, ALU opcode localparams, and the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
- Single module; no sub-module. The settle counter is a 4-bit local register.

Test Plan:
Bench drives alu_res from a stub: res = a*b + cin, combinational from alu_*.
- Reset: rst=1 mid-WAIT with a=8'h12 -> immediately req_ready=1, rsp_valid=0, alu_a=0, issue_count=0. No response appears after release.
- Single op, SETTLE=1: a=8'hFF, b=8'hFF, cin=0, op=3'd2 -> rsp_valid high 1 edge after accept. rsp_res=16'hFE01, rsp_op=3'd2, rsp_zero=0.
- Zero flag: a=8'h00, b=8'h37, cin=0 -> rsp_res=16'h0000, rsp_zero=1. With cin=1 -> rsp_res=16'h0001, rsp_zero=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_res stable, req_ready=0 throughout. Release -> single transfer.
- Back-to-back: rsp_ready=1 and req_valid=1 continuously for 4 requests (a=1..4, b=3) -> results 3, 6, 9, 12 in order, with one response every SETTLE+1 cycles.
- Counter wrap and SETTLE=4: issue 256 requests -> issue_count returns to 0, and each rsp_valid rises exactly 4 edges after its accept.
